// File: rtl/ysyx_041461_pipe_ctrl.sv
// Pipeline sequencer for the six-stage core: per-stage hold/bubble controls, PC redirect, trap drain FSM.
// Latency: all controls combinational from inputs and state; state (and optional counters) update on posedge clk.
// Backpressure: the latest stalling stage holds itself and all earlier stages; a bubble enters the stage after it.
//
// Ports:
//   clk, rst                      core clock, asynchronous active-high reset
//   if_busy, mem_busy             fetch / load-store outstanding
//   id_/exe_/mem_conflict         hazards from the conflict detector
//   trap_pending, wb_trap_commit  trap somewhere in IF2..WB / trap retiring in WB this cycle
//   id_branch_taken               ID resolved a taken branch or jump
//   *_stall, *_flush, pc_redirect per-stage hold, bubble insert, PC redirect strobe
//   state                         FSM state for debug (RUN=0, DRAIN=1, FLUSH=2)
//   perf_stall_cyc, perf_flush_evt  wrapping performance counters (only with YSYX_041461_PIPE_CTRL_PERF_EN)
//
// Optional feature macro: YSYX_041461_PIPE_CTRL_PERF_EN adds parameter CNT_W and the two counters.
module ysyx_041461_pipe_ctrl
`ifdef YSYX_041461_PIPE_CTRL_PERF_EN
#(
  parameter int CNT_W = 32
)
`endif
(
  input  logic             clk,
  input  logic             rst,
  input  logic             if_busy,
  input  logic             mem_busy,
  input  logic             id_conflict,
  input  logic             exe_conflict,
  input  logic             mem_conflict,
  input  logic             trap_pending,
  input  logic             wb_trap_commit,
  input  logic             id_branch_taken,
  output logic             if_stall,
  output logic             if2_stall,
  output logic             id_stall,
  output logic             exe_stall,
  output logic             mem_stall,
  output logic             if2_flush,
  output logic             id_flush,
  output logic             exe_flush,
  output logic             mem_flush,
  output logic             wb_flush,
  output logic             pc_redirect,
`ifdef YSYX_041461_PIPE_CTRL_PERF_EN
  output logic [CNT_W-1:0] perf_stall_cyc,
  output logic [CNT_W-1:0] perf_flush_evt,
`endif
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } pipe_state_e;

  pipe_state_e state_q;
  pipe_state_e state_d;

  logic s_mem;
  logic commit;

  assign s_mem  = mem_busy | mem_conflict;
  // A commit seen in FLUSH is ignored: only bubbles are in flight then.
  assign commit = wb_trap_commit && (state_q != FLUSH);
  assign state  = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (wb_trap_commit) begin
          state_d = FLUSH;
        end else if (trap_pending) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (wb_trap_commit) begin
          state_d = FLUSH;
        end
      end
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    if_stall    = 1'b0;
    if2_stall   = 1'b0;
    id_stall    = 1'b0;
    exe_stall   = 1'b0;
    mem_stall   = 1'b0;
    if2_flush   = 1'b0;
    id_flush    = 1'b0;
    exe_flush   = 1'b0;
    mem_flush   = 1'b0;
    wb_flush    = 1'b0;
    pc_redirect = 1'b0;

    // Only the latest stalling stage matters; earlier sources are implied by its hold.
    if (s_mem) begin
      {if_stall, if2_stall, id_stall, exe_stall, mem_stall} = 5'b11111;
      wb_flush = 1'b1;
    end else if (exe_conflict) begin
      {if_stall, if2_stall, id_stall, exe_stall} = 4'b1111;
      mem_flush = 1'b1;
    end else if (id_conflict) begin
      {if_stall, if2_stall, id_stall} = 3'b111;
      exe_flush = 1'b1;
    end else if (if_busy) begin
      if_stall  = 1'b1;
      if2_flush = 1'b1;
    end

    // Branches resolve only in RUN; a held ID re-presents the branch once released.
    // In DRAIN/FLUSH the younger instructions are doomed or bubbles, so no redirect.
    if ((state_q == RUN) && id_branch_taken && !id_stall) begin
      pc_redirect = 1'b1;
      if2_flush   = 1'b1;
      id_flush    = 1'b1;
    end

    // Fetch is frozen while a trap drains and for the CSR-settle cycle after commit.
    if (state_q != RUN) begin
      if_stall  = 1'b1;
      if2_flush = 1'b1;
    end

    if (commit) begin
      {if_stall, if2_stall, id_stall, exe_stall, mem_stall}   = 5'b00000;
      {if2_flush, id_flush, exe_flush, mem_flush, wb_flush}   = 5'b11111;
      pc_redirect = 1'b1;
    end

    if (rst) begin
      {if_stall, if2_stall, id_stall, exe_stall, mem_stall}   = 5'b00000;
      {if2_flush, id_flush, exe_flush, mem_flush, wb_flush}   = 5'b11111;
      pc_redirect = 1'b0;
    end
  end

`ifdef YSYX_041461_PIPE_CTRL_PERF_EN
  logic any_stall;
  assign any_stall = if_stall | if2_stall | id_stall | exe_stall | mem_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cyc <= '0;
      perf_flush_evt <= '0;
    end else begin
      if (any_stall) begin
        perf_stall_cyc <= perf_stall_cyc + 1'b1;
      end
      if (pc_redirect) begin
        perf_flush_evt <= perf_flush_evt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/ysyx_041461_pipe_ctrl.md
# ysyx_041461_pipe_ctrl

Pipeline sequencer for the six-stage core (IF, IF2, ID, EXE, MEM, WB):
- Consumes the conflict detector's per-stage conflict and trap flags, the memory-busy flags and the ID branch-redirect flag.
- Produces per-stage hold and bubble-insert controls plus the PC redirect strobe.
- Owns the trap drain state machine: fetch stops while a trap travels to WB, then the whole pipe is flushed on commit.
- Sits beside the conflict detector; every stage register consumes its outputs.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter (only with the Configuration macro)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- if_busy  in  1  instruction fetch outstanding
- mem_busy  in  1  load/store outstanding
- id_conflict  in  1  ID source hazard (from conflict detector)
- exe_conflict  in  1  EXE source hazard
- mem_conflict  in  1  MEM store-data hazard
- trap_pending  in  1  any valid stage IF2..WB carries a trap (detector's IF trap flag)
- wb_trap_commit  in  1  WB retires a trapping instruction (ecall/ebreak/mret) this cycle
- id_branch_taken  in  1  ID resolved a taken branch or jump
- if_stall, if2_stall, id_stall, exe_stall, mem_stall  out  1 each  hold stage register
- if2_flush, id_flush, exe_flush, mem_flush, wb_flush  out  1 each  load bubble into stage register next edge
- pc_redirect  out  1  PC loads redirect target this edge
- state  out  2  FSM state for debug: RUN=0, DRAIN=1, FLUSH=2
- perf_stall_cyc, perf_flush_evt  out  CNT_W each  performance counters (macro only)

## Operation
Stall source is the latest stalling stage:
- S_mem = mem_busy | mem_conflict
- S_exe = exe_conflict
- S_id = id_conflict
- S_if = if_busy

Stall rule for the latest active source at stage X:
- Hold X and every earlier stage.
- Assert the flush of the stage directly after X (bubble insert).
- Earlier sources are masked.
- Example: S_mem=1 and S_id=1 gives all stalls IF..MEM =1, wb_flush=1, exe_flush=0.

Branch rule:
- id_branch_taken=1 and id_stall=0 gives pc_redirect=1, if2_flush=1, id_flush=1.
- If id_stall=1, the branch is ignored this cycle and re-evaluated when ID is released.

FSM:
- RUN:
  - trap_pending=1 and wb_trap_commit=0 → DRAIN.
  - wb_trap_commit=1 → FLUSH; apply the commit action this cycle.
- DRAIN:
  - if_stall forced 1 and if2_flush forced 1: no new fetch enters.
  - Later stages keep the normal stall rule.
  - id_branch_taken is ignored.
  - wb_trap_commit=1 → FLUSH with the commit action.
  - Otherwise stays in DRAIN.
- Commit action (combinational, in the commit cycle): pc_redirect=1, all five flush outputs =1, all stall outputs =0. This overrides every stall and branch rule.
- FLUSH: lasts exactly one cycle, so CSR writes settle before fetch resumes.
  - if_stall=1, if2_flush=1, other stages run normally (they hold bubbles).
  - Unconditional → RUN.
- A wb_trap_commit arriving in FLUSH is ignored (the pipe holds only bubbles).

## Timing
- All outputs except the counters are combinational from inputs and state; state updates on the posedge clk.
- Redirect latency: pc_redirect is high in the same cycle as id_branch_taken or wb_trap_commit.
- Trap latency: the first new fetch is issued 2 cycles after the commit cycle (commit cycle, then FLUSH, then RUN issues).
- While rst=1:
  - state=RUN.
  - All stalls =0, all flushes =1, pc_redirect=0.
  - Counters =0.
- Reset mid-DRAIN or mid-FLUSH returns immediately to RUN; no redirect is issued.
- if_busy held in DRAIN has no extra effect (IF is already held).

## Configuration
- YSYX_041461_PIPE_CTRL_PERF_EN defined:
  - perf_stall_cyc increments each cycle any stall output is 1.
  - perf_flush_evt increments each cycle pc_redirect=1.
  - Both wrap modulo 2^CNT_W and are registered.
- Undefined: both ports and counters are absent; no other behaviour changes.

## Test plan
- Reset: rst=1 → state=0, all flush=1, stalls=0, pc_redirect=0; release → RUN, all outputs 0 with idle inputs.
- mem_busy=1 with id_conflict=1 for 3 cycles → IF..MEM stalls=1 and wb_flush=1 for 3 cycles, exe_flush=0; drop → all 0.
- id_branch_taken=1 alone → pc_redirect=1, if2_flush=1, id_flush=1; repeated with exe_conflict=1 → pc_redirect=0, EXE and earlier held, mem_flush=1.
- trap_pending=1 for 4 cycles then wb_trap_commit=1 → state 1 for 4 cycles with if_stall=1; commit cycle shows all flushes=1 and pc_redirect=1; next cycle state=2; then state=0.
- rst asserted during DRAIN → state=0 asynchronously, no pc_redirect pulse.
- With YSYX_041461_PIPE_CTRL_PERF_EN and CNT_W=4: 17 stall cycles → perf_stall_cyc=1 (wrap); 2 redirects → perf_flush_evt=2.
